// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Shares the single register-file write port between the pipeline WB stage and a
// multi-cycle execution unit. WB writes always take the port; multi-cycle results
// wait in a small FIFO and drain into cycles where WB does not write. A per-register
// scoreboard holds ID while a source depends on a multi-cycle result that has been
// issued but not yet written back.
module reg_write_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic              Clk,
   input  logic              Reset_n,
   // pipeline WB stage
   input  logic              RegWrite_WB_In,
   input  logic [ADDR_W-1:0] Write_Register_WB_In,
   input  logic [DATA_W-1:0] Write_Data_WB_In,
   // multi-cycle unit result handshake
   input  logic              MC_Valid,
   output logic              MC_Ready,
   input  logic [ADDR_W-1:0] MC_Write_Register,
   input  logic [DATA_W-1:0] MC_Write_Data,
   // ID stage issue and source operands
   input  logic              MC_Issue,
   input  logic [ADDR_W-1:0] MC_Issue_Register,
   input  logic [ADDR_W-1:0] Read_Address_1_ID,
   input  logic [ADDR_W-1:0] Read_Address_2_ID,
   output logic              Stall_ID,
   output logic              Pipe_Hold,
   // register-file write port
   output logic              RegWrite_WB,
   output logic [ADDR_W-1:0] Write_Register_WB,
   output logic [DATA_W-1:0] Write_Data_WB
);

   localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W    = PTR_W + 1;
   localparam int NUM_REGS = 1 << ADDR_W;
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   // ------------------------------------------------------------------
   // Request qualification
   // ------------------------------------------------------------------
   logic wb_valid;
   logic fifo_empty;
   logic push_accept;
   logic push_store;
   logic pop;
   logic issue_accept;

   // Result queue state
   logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg,  count_next;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   // Scoreboard and starvation tracking
   logic [NUM_REGS-1:0] busy_reg, busy_next;
   logic [STARVE_W-1:0] starve_reg, starve_next;
   logic                pipe_hold_reg;

   // Registered write port
   logic              regwrite_reg;
   logic [ADDR_W-1:0] write_register_reg;
   logic [DATA_W-1:0] write_data_reg;

   // A WB write to r0 has no architectural effect, so it does not claim the port.
   assign wb_valid   = RegWrite_WB_In && (Write_Register_WB_In != '0);
   assign fifo_empty = (count_reg == '0);

   // Ready looks only at the current occupancy; a pop in the same cycle does not
   // open a slot early, which keeps MC_Ready a clean function of registered state.
   assign MC_Ready    = (count_reg < CNT_W'(FIFO_DEPTH));
   assign push_accept = MC_Valid && MC_Ready;
   // Results aimed at r0 complete the handshake but are never stored.
   assign push_store  = push_accept && (MC_Write_Register != '0);
   // The queue drains only into cycles that WB leaves idle.
   assign pop         = !wb_valid && !fifo_empty;

   assign head_addr = fifo_addr_mem[rd_ptr_reg];
   assign head_data = fifo_data_mem[rd_ptr_reg];

   // ------------------------------------------------------------------
   // Result FIFO
   // ------------------------------------------------------------------
   // Pointer and occupancy next-state; depth is a power of two so pointers wrap.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push_store) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push_store, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Queue storage: written on an accepted, non-r0 push; contents need no reset.
   always_ff @(posedge Clk) begin
      if (push_store) begin
         fifo_addr_mem[wr_ptr_reg] <= MC_Write_Register;
         fifo_data_mem[wr_ptr_reg] <= MC_Write_Data;
      end
   end

   // Queue pointers and occupancy; reset discards everything queued.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // ------------------------------------------------------------------
   // Destination scoreboard
   // ------------------------------------------------------------------
   // r0 is never busy, so an r0 operand or issue can never raise a stall.
   assign Stall_ID = busy_reg[Read_Address_1_ID]
                   | busy_reg[Read_Address_2_ID]
                   | (MC_Issue && busy_reg[MC_Issue_Register]);

   // An issue that arrives while ID is stalled is dropped, which also rules out
   // a second outstanding writer to the same register.
   assign issue_accept = MC_Issue && !Stall_ID && (MC_Issue_Register != '0);

   // Each busy bit sets on an accepted issue and clears when its result is
   // popped onto the port; a same-cycle set keeps the bit high.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         if (gi == 0) begin : g_r0
            assign busy_next[gi] = 1'b0;
         end else begin : g_rn
            assign busy_next[gi] =
                 (issue_accept && (MC_Issue_Register == ADDR_W'(gi)))
               | (busy_reg[gi] && !(pop && (head_addr == ADDR_W'(gi))));
         end
      end
   endgenerate

   // Scoreboard register.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   // ------------------------------------------------------------------
   // Starvation detection
   // ------------------------------------------------------------------
   // Counts consecutive cycles where WB owns the port while results are waiting;
   // any cycle without that condition (including a pop) restarts the count.
   always_comb begin
      starve_next = '0;
      if (wb_valid && !fifo_empty) begin
         if (starve_reg == STARVE_W'(STARVE_MAX)) begin
            starve_next = starve_reg;
         end else begin
            starve_next = starve_reg + STARVE_W'(1);
         end
      end
   end

   // Counter plus registered hold request derived from the saturated count.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         starve_reg    <= '0;
         pipe_hold_reg <= 1'b0;
      end else begin
         starve_reg    <= starve_next;
         pipe_hold_reg <= (starve_reg == STARVE_W'(STARVE_MAX));
      end
   end

   assign Pipe_Hold = pipe_hold_reg;

   // ------------------------------------------------------------------
   // Write port
   // ------------------------------------------------------------------
   // WB has priority, otherwise the FIFO head; address/data hold when idle.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         regwrite_reg       <= 1'b0;
         write_register_reg <= '0;
         write_data_reg     <= '0;
      end else if (wb_valid) begin
         regwrite_reg       <= 1'b1;
         write_register_reg <= Write_Register_WB_In;
         write_data_reg     <= Write_Data_WB_In;
      end else if (pop) begin
         regwrite_reg       <= 1'b1;
         write_register_reg <= head_addr;
         write_data_reg     <= head_data;
      end else begin
         regwrite_reg       <= 1'b0;
      end
   end

   assign RegWrite_WB       = regwrite_reg;
   assign Write_Register_WB = write_register_reg;
   assign Write_Data_WB     = write_data_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
// Directed vectors with hand-computed expectations for reg_write_arbiter.
module tb_reg_write_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              Clk;
   logic              Reset_n;
   logic              RegWrite_WB_In;
   logic [ADDR_W-1:0] Write_Register_WB_In;
   logic [DATA_W-1:0] Write_Data_WB_In;
   logic              MC_Valid;
   logic              MC_Ready;
   logic [ADDR_W-1:0] MC_Write_Register;
   logic [DATA_W-1:0] MC_Write_Data;
   logic              MC_Issue;
   logic [ADDR_W-1:0] MC_Issue_Register;
   logic [ADDR_W-1:0] Read_Address_1_ID;
   logic [ADDR_W-1:0] Read_Address_2_ID;
   logic              Stall_ID;
   logic              Pipe_Hold;
   logic              RegWrite_WB;
   logic [ADDR_W-1:0] Write_Register_WB;
   logic [DATA_W-1:0] Write_Data_WB;

   int pass_count  = 0;
   int check_count = 0;

   reg_write_arbiter #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .FIFO_DEPTH(2),
      .STARVE_MAX(8)
   ) dut (
      .Clk                 (Clk),
      .Reset_n             (Reset_n),
      .RegWrite_WB_In      (RegWrite_WB_In),
      .Write_Register_WB_In(Write_Register_WB_In),
      .Write_Data_WB_In    (Write_Data_WB_In),
      .MC_Valid            (MC_Valid),
      .MC_Ready            (MC_Ready),
      .MC_Write_Register   (MC_Write_Register),
      .MC_Write_Data       (MC_Write_Data),
      .MC_Issue            (MC_Issue),
      .MC_Issue_Register   (MC_Issue_Register),
      .Read_Address_1_ID   (Read_Address_1_ID),
      .Read_Address_2_ID   (Read_Address_2_ID),
      .Stall_ID            (Stall_ID),
      .Pipe_Hold           (Pipe_Hold),
      .RegWrite_WB         (RegWrite_WB),
      .Write_Register_WB   (Write_Register_WB),
      .Write_Data_WB       (Write_Data_WB)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_count++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         pass_count++;
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one clock and settle past the edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wb_drive(input logic en, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      RegWrite_WB_In       = en;
      Write_Register_WB_In = addr;
      Write_Data_WB_In     = data;
   endtask

   task automatic mc_drive(input logic en, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      MC_Valid          = en;
      MC_Write_Register = addr;
      MC_Write_Data     = data;
   endtask

   initial begin
      Reset_n           = 1'b0;
      wb_drive(1'b0, '0, '0);
      mc_drive(1'b0, '0, '0);
      MC_Issue          = 1'b0;
      MC_Issue_Register = '0;
      Read_Address_1_ID = '0;
      Read_Address_2_ID = '0;

      // ---------------- 1: power-up reset ----------------
      tick();
      tick();
      check_value("rst_regwrite", 64'(RegWrite_WB), 64'd0);
      check_value("rst_addr", 64'(Write_Register_WB), 64'd0);
      check_value("rst_data", 64'(Write_Data_WB), 64'd0);
      check_value("rst_pipe_hold", 64'(Pipe_Hold), 64'd0);
      check_value("rst_mc_ready", 64'(MC_Ready), 64'd1);
      check_value("rst_stall", 64'(Stall_ID), 64'd0);
      Reset_n = 1'b1;
      tick();

      // ---------------- 2: WB only ----------------
      wb_drive(1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      check_value("wb_regwrite", 64'(RegWrite_WB), 64'd1);
      check_value("wb_addr", 64'(Write_Register_WB), 64'd5);
      check_value("wb_data", 64'(Write_Data_WB), 64'hDEADBEEF);
      wb_drive(1'b1, 5'd0, 32'h12345678);
      tick();
      check_value("wb_r0_ignored", 64'(RegWrite_WB), 64'd0);
      wb_drive(1'b0, '0, '0);

      // ---------------- 3: WB / MC conflict ----------------
      MC_Issue          = 1'b1;
      MC_Issue_Register = 5'd7;
      #1;
      check_value("issue7_no_stall", 64'(Stall_ID), 64'd0);
      tick();
      MC_Issue          = 1'b0;
      Read_Address_1_ID = 5'd7;
      #1;
      check_value("rs7_stall", 64'(Stall_ID), 64'd1);
      wb_drive(1'b1, 5'd3, 32'h11);
      mc_drive(1'b1, 5'd7, 32'h22);
      tick();
      wb_drive(1'b0, '0, '0);
      mc_drive(1'b0, '0, '0);
      check_value("conf_wb_first_addr", 64'(Write_Register_WB), 64'd3);
      check_value("conf_wb_first_data", 64'(Write_Data_WB), 64'h11);
      check_value("conf_rs7_still_busy", 64'(Stall_ID), 64'd1);
      tick();
      check_value("conf_mc_regwrite", 64'(RegWrite_WB), 64'd1);
      check_value("conf_mc_addr", 64'(Write_Register_WB), 64'd7);
      check_value("conf_mc_data", 64'(Write_Data_WB), 64'h22);
      check_value("conf_busy7_cleared", 64'(Stall_ID), 64'd0);
      Read_Address_1_ID = '0;
      tick();

      // ---------------- 4: full FIFO and starvation ----------------
      wb_drive(1'b1, 5'd1, 32'h100);
      mc_drive(1'b1, 5'd10, 32'hA0);
      tick();                                   // edge 1: push r10
      check_value("full_ready_one", 64'(MC_Ready), 64'd1);
      mc_drive(1'b1, 5'd11, 32'hB0);
      tick();                                   // edge 2: push r11, now full
      check_value("full_ready_zero", 64'(MC_Ready), 64'd0);
      mc_drive(1'b1, 5'd12, 32'hC0);
      tick();                                   // edge 3: r12 refused
      mc_drive(1'b0, '0, '0);
      check_value("full_still_zero", 64'(MC_Ready), 64'd0);
      for (int i = 0; i < 2; i++) tick();       // edges 4-5
      check_value("starve_early_no_hold", 64'(Pipe_Hold), 64'd0);
      for (int i = 0; i < 6; i++) tick();       // edges 6-11
      check_value("starve_hold", 64'(Pipe_Hold), 64'd1);
      check_value("starve_wb_owns_port", 64'(Write_Register_WB), 64'd1);
      wb_drive(1'b0, '0, '0);
      tick();                                   // edge 12: pop r10
      check_value("drain_ready", 64'(MC_Ready), 64'd1);
      check_value("drain1_addr", 64'(Write_Register_WB), 64'd10);
      check_value("drain1_data", 64'(Write_Data_WB), 64'hA0);
      tick();                                   // edge 13: pop r11
      check_value("drain2_addr", 64'(Write_Register_WB), 64'd11);
      check_value("drain2_data", 64'(Write_Data_WB), 64'hB0);
      check_value("drain_hold_dropped", 64'(Pipe_Hold), 64'd0);
      tick();                                   // edge 14: queue empty
      check_value("drain_idle", 64'(RegWrite_WB), 64'd0);

      // ---------------- 5: scoreboard ----------------
      MC_Issue          = 1'b1;
      MC_Issue_Register = 5'd9;
      tick();
      MC_Issue          = 1'b0;
      Read_Address_1_ID = 5'd9;
      #1;
      check_value("sb_rs9_stall", 64'(Stall_ID), 64'd1);
      Read_Address_1_ID = '0;
      MC_Issue          = 1'b1;
      #1;
      check_value("sb_reissue9_stall", 64'(Stall_ID), 64'd1);
      tick();
      MC_Issue = 1'b0;
      #1;
      check_value("sb_rs0_no_stall", 64'(Stall_ID), 64'd0);
      Read_Address_1_ID = 5'd9;
      mc_drive(1'b1, 5'd9, 32'h99);
      tick();                                   // push r9
      mc_drive(1'b0, '0, '0);
      check_value("sb_queued_stall", 64'(Stall_ID), 64'd1);
      tick();                                   // pop r9
      check_value("sb_r9_written", 64'(Write_Register_WB), 64'd9);
      check_value("sb_r9_released", 64'(Stall_ID), 64'd0);

      // ---------------- 6: pop r9 and issue r9 together ----------------
      Read_Address_1_ID = '0;
      mc_drive(1'b1, 5'd9, 32'h199);
      tick();                                   // push orphan r9 result
      mc_drive(1'b0, '0, '0);
      MC_Issue          = 1'b1;
      MC_Issue_Register = 5'd9;
      #1;
      check_value("same_issue_allowed", 64'(Stall_ID), 64'd0);
      tick();                                   // pop r9 + issue r9
      MC_Issue          = 1'b0;
      Read_Address_1_ID = 5'd9;
      #1;
      check_value("same_pop_data", 64'(Write_Data_WB), 64'h199);
      check_value("same_busy9_kept", 64'(Stall_ID), 64'd1);
      Read_Address_1_ID = '0;

      // ---------------- 1b: reset in the middle of a queue ----------------
      MC_Issue          = 1'b1;
      MC_Issue_Register = 5'd20;
      wb_drive(1'b1, 5'd2, 32'h200);
      mc_drive(1'b1, 5'd20, 32'h2020);
      tick();
      MC_Issue = 1'b0;
      mc_drive(1'b1, 5'd21, 32'h2121);
      tick();
      mc_drive(1'b0, '0, '0);
      Read_Address_2_ID = 5'd20;
      #1;
      check_value("mid_pre_full", 64'(MC_Ready), 64'd0);
      Reset_n = 1'b0;
      wb_drive(1'b0, '0, '0);
      tick();
      tick();
      check_value("mid_rst_regwrite", 64'(RegWrite_WB), 64'd0);
      check_value("mid_rst_ready", 64'(MC_Ready), 64'd1);
      check_value("mid_rst_stall", 64'(Stall_ID), 64'd0);
      check_value("mid_rst_hold", 64'(Pipe_Hold), 64'd0);
      Reset_n = 1'b1;
      tick();
      check_value("mid_queue_discarded", 64'(RegWrite_WB), 64'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
